// File: rtl/uart_pkg.sv
// Shared types and constants for the uart receive-side FIFO.
package uart_pkg;

    localparam int unsigned UART_RX_FIFO_DEPTH = 16;
    localparam int unsigned UART_DATA_W        = 8;

    // One FIFO slot: received byte plus its parity-error flag.
    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

    // Receive handshake states.
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_CAPTURE = 2'd1,
        RX_ACK     = 2'd2
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single level signal from another clock domain.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO between the uart receiver and the Nios.
// Optional build macro: UART_RX_FIFO_DROP_PARITY_ERR_EN discards bytes that
// arrive with a parity error and counts them on parity_drop_cnt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   new_data,
    input  logic [UART_DATA_W-1:0] data_in_nios,
    input  logic                   parity_status,
    output logic                   data_read_nios,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_parity_err,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
`ifdef UART_RX_FIFO_DROP_PARITY_ERR_EN
    output logic [7:0]             parity_drop_cnt,
`endif
    input  logic                   clr_overflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    localparam logic [1:0] IDLE    = RX_IDLE;
    localparam logic [1:0] CAPTURE = RX_CAPTURE;
    localparam logic [1:0] ACK     = RX_ACK;

    logic             nd_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             ack_q;
    logic             ack_d;
    logic             capture_c;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             overflow_q;
    logic             overflow_d;

    uart_rx_entry_t   mem_q [DEPTH];
    uart_rx_entry_t   entry_c;
    uart_rx_entry_t   head_c;

    logic             push_c;
    logic             pop_c;
    logic             wr_en_c;
    logic             ovf_set_c;

    uart_rx_sync u_sync (
        .clk_i  (sys_clk),
        .rst_ni (reset),
        .d_i    (new_data),
        .q_o    (nd_s)
    );

    // Handshake state and acknowledge registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic; the byte is pushed on the IDLE->CAPTURE edge so the
    // entry lands three edges after new_data rises, CAPTURE then lets the
    // push settle before the acknowledge is raised.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (nd_s) begin
                    state_d   = CAPTURE;
                    capture_c = 1'b1;
                end
            end
            CAPTURE: begin
                state_d = ACK;
            end
            ACK: begin
                if (!nd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d = (state_d == ACK);
    end

    assign data_read_nios = ack_q;

    // Data path is only sampled once nd_s is high, so it is already stable.
    always_comb begin
        entry_c      = '0;
        entry_c.perr = parity_status;
        entry_c.data = data_in_nios;
    end

`ifdef UART_RX_FIFO_DROP_PARITY_ERR_EN
    logic       pdrop_c;
    logic [7:0] pdrop_q;
    logic [7:0] pdrop_d;

    assign push_c  = capture_c & ~parity_status;
    assign pdrop_c = capture_c &  parity_status;

    // Saturating parity-drop counter; a drop in the clearing cycle still counts.
    always_comb begin
        pdrop_d = pdrop_q;
        if (clr_overflow) begin
            pdrop_d = pdrop_c ? 8'd1 : 8'd0;
        end else if (pdrop_c && (pdrop_q != 8'hFF)) begin
            pdrop_d = pdrop_q + 8'd1;
        end
    end

    // Parity-drop counter register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            pdrop_q <= 8'd0;
        end else begin
            pdrop_q <= pdrop_d;
        end
    end

    assign parity_drop_cnt = pdrop_q;
`else
    assign push_c = capture_c;
`endif

    // Occupancy flags decoded from the registered pointers.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign pop_c     = rd_en & ~empty;
    assign wr_en_c   = push_c & (~full | pop_c);
    assign ovf_set_c = push_c & full & ~pop_c;

    // Pointer and sticky-overflow next state; a new overflow beats the clear.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Pointer and overflow registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    // Storage array; intentionally not reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= entry_c;
        end
    end

    // First-word-fall-through head, zeroed while empty.
    assign head_c  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign rd_data = empty ? '0 : head_c.data;
`ifdef UART_RX_FIFO_DROP_PARITY_ERR_EN
    assign rd_parity_err = 1'b0;
`else
    assign rd_parity_err = empty ? 1'b0 : head_c.perr;
`endif

endmodule
